// File: rtl/halo_merge_arbiter.sv
// rtl/halo_merge_arbiter.sv - round-robin merge of 8 neighbour halo writes into the local partial-sum buffer
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   bitwidth                activation bitwidth mode (3 behaves as 0), static during a merge
//   merge_start             pulse; clears merge_done and protocol_error
//   in_value/in_row/in_column/in_write_enable   per-neighbour halo write (index 0..7)
//   neighbor_cts            per-neighbour clear to send (slot empty)
//   neighbor_exchange_done  per-neighbour level, neighbour finished sending
//   buffer_grant            buffer port free for a new read this cycle
//   buffer_read_*           read issue (data returns one cycle later on buffer_data_read)
//   buffer_write_*          accumulated write-back
//   merge_done              all halo traffic merged
//   protocol_error          sticky; write arrived while cts was low
module halo_merge_arbiter #(
    parameter int BANK_COUNT = 32,
    parameter int TILE_SIZE  = 128,
    parameter int DATA_WIDTH = 16,
    localparam int ROW_W     = $clog2(TILE_SIZE),
    localparam int BANK_W    = $clog2(BANK_COUNT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            bitwidth,
    input  logic                  merge_start,
    input  logic [DATA_WIDTH-1:0] in_value [8],
    input  logic [ROW_W-1:0]      in_row [8],
    input  logic [ROW_W-1:0]      in_column [8],
    input  logic [7:0]            in_write_enable,
    output logic [7:0]            neighbor_cts,
    input  logic [7:0]            neighbor_exchange_done,
    input  logic                  buffer_grant,
    output logic                  buffer_read_enable,
    output logic [BANK_W-1:0]     buffer_read_bank,
    output logic [ROW_W-1:0]      buffer_read_entry,
    input  logic [DATA_WIDTH-1:0] buffer_data_read,
    output logic                  buffer_write_enable,
    output logic [BANK_W-1:0]     buffer_write_bank,
    output logic [ROW_W-1:0]      buffer_write_entry,
    output logic [DATA_WIDTH-1:0] buffer_write_data,
    output logic                  merge_done,
    output logic                  protocol_error
);

    // Holding slots, one per neighbour
    logic [7:0]            slot_valid;
    logic [DATA_WIDTH-1:0] slot_value [8];
    logic [ROW_W-1:0]      slot_row [8];
    logic [ROW_W-1:0]      slot_col [8];

    logic [2:0]            rr_ptr;

    // Arbitration / S0
    logic                  issue;
    logic                  win_found;
    logic [2:0]            win_idx;
    logic [1:0]            bw_eff;
    logic [ROW_W-1:0]      row_upper;
    logic [ROW_W-1:0]      row_section;
    logic [BANK_W-1:0]     issue_bank;

    // S1 accumulate stage
    logic                  s1_valid;
    logic [BANK_W-1:0]     s1_bank;
    logic [ROW_W-1:0]      s1_entry;
    logic [DATA_WIDTH-1:0] s1_value;
    logic                  fwd_valid;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] operand;
    logic [DATA_WIDTH-1:0] s1_sum;
    logic                  hazard_hit;

    logic                  violation;
    logic                  done_cond;

    assign neighbor_cts = reset ? 8'h00 : ~slot_valid;

    // First valid slot scanning upward from rr_ptr+1; k=8 wraps back to rr_ptr itself.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            if (!win_found && slot_valid[rr_ptr + 3'(k)]) begin
                win_found = 1'b1;
                win_idx   = rr_ptr + 3'(k);
            end
        end
    end

    assign issue = !reset && buffer_grant && win_found;

    // Address map. All bank arithmetic is done at BANK_W bits, which is exactly
    // the mod BANK_COUNT reduction since BANK_COUNT is a power of two.
    assign bw_eff      = (bitwidth == 2'd3) ? 2'd0 : bitwidth;
    assign row_upper   = slot_row[win_idx] >> bw_eff;
    assign row_section = slot_row[win_idx] & ~({ROW_W{1'b1}} << bw_eff);
    assign issue_bank  = BANK_W'(slot_col[win_idx])
                       + BANK_W'(row_upper) * BANK_W'(3)
                       + BANK_W'(row_section) * BANK_W'(BANK_COUNT >> bw_eff);

    assign buffer_read_enable = issue;
    assign buffer_read_bank   = issue_bank;
    assign buffer_read_entry  = row_upper;

    // The buffer returns stale data when a read and write collide, so a read
    // issued against the address S1 is writing takes the S1 sum next cycle.
    assign operand    = fwd_valid ? fwd_data : buffer_data_read;
    assign s1_sum     = s1_value + operand;
    assign hazard_hit = issue && s1_valid && (issue_bank == s1_bank) && (row_upper == s1_entry);

    assign buffer_write_enable = s1_valid && !reset;
    assign buffer_write_bank   = s1_bank;
    assign buffer_write_entry  = s1_entry;
    assign buffer_write_data   = s1_sum;

    assign violation = |(in_write_enable & slot_valid);
    // S1 commits its write this cycle, so only the slots need to be empty.
    assign done_cond = (&neighbor_exchange_done) && !(|slot_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (issue && (win_idx == 3'(i))) begin
                    slot_valid[i] <= 1'b0;
                end else if (in_write_enable[i] && !slot_valid[i]) begin
                    slot_valid[i] <= 1'b1;
                    slot_value[i] <= in_value[i];
                    slot_row[i]   <= in_row[i];
                    slot_col[i]   <= in_column[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= 3'd7;
            s1_valid  <= 1'b0;
            fwd_valid <= 1'b0;
        end else begin
            s1_valid  <= issue;
            fwd_valid <= hazard_hit;
            fwd_data  <= s1_sum;
            if (issue) begin
                rr_ptr   <= win_idx;
                s1_bank  <= issue_bank;
                s1_entry <= row_upper;
                s1_value <= slot_value[win_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            merge_done     <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            if (merge_start) begin
                merge_done <= 1'b0;
            end else if (done_cond) begin
                merge_done <= 1'b1;
            end
            if (merge_start) begin
                protocol_error <= 1'b0;
            end else if (violation) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_halo_merge_arbiter.sv
// tb/tb_halo_merge_arbiter.sv - scoreboard bench for halo_merge_arbiter
module tb_halo_merge_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  bitwidth;
    logic        merge_start;
    logic [15:0] in_value [8];
    logic [6:0]  in_row [8];
    logic [6:0]  in_column [8];
    logic [7:0]  in_write_enable;
    logic [7:0]  neighbor_cts;
    logic [7:0]  neighbor_exchange_done;
    logic        buffer_grant;
    logic        buffer_read_enable;
    logic [4:0]  buffer_read_bank;
    logic [6:0]  buffer_read_entry;
    logic [15:0] buffer_data_read;
    logic        buffer_write_enable;
    logic [4:0]  buffer_write_bank;
    logic [6:0]  buffer_write_entry;
    logic [15:0] buffer_write_data;
    logic        merge_done;
    logic        protocol_error;

    always #5 clk = ~clk;

    halo_merge_arbiter dut (
        .clk(clk), .reset(reset), .bitwidth(bitwidth), .merge_start(merge_start),
        .in_value(in_value), .in_row(in_row), .in_column(in_column),
        .in_write_enable(in_write_enable), .neighbor_cts(neighbor_cts),
        .neighbor_exchange_done(neighbor_exchange_done), .buffer_grant(buffer_grant),
        .buffer_read_enable(buffer_read_enable), .buffer_read_bank(buffer_read_bank),
        .buffer_read_entry(buffer_read_entry), .buffer_data_read(buffer_data_read),
        .buffer_write_enable(buffer_write_enable), .buffer_write_bank(buffer_write_bank),
        .buffer_write_entry(buffer_write_entry), .buffer_write_data(buffer_write_data),
        .merge_done(merge_done), .protocol_error(protocol_error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Buffer contents as seen by the DUT, and the reference cell values.
    logic [15:0] mem    [32][128];
    logic [15:0] golden [32][128];

    task automatic set_cell(input int bank, input int entry, input logic [15:0] v);
        mem[bank][entry]    = v;
        golden[bank][entry] = v;
    endtask

    typedef struct {
        logic [7:0] cts;
        logic       re;
        logic       we;
        logic       err;
        logic       done;
    } status_t;

    typedef struct {
        int          bank;
        int          entry;
        logic [15:0] data;
    } acc_t;

    status_t stq[$];
    acc_t    rdq[$];
    acc_t    wrq[$];

    // Transaction-level reference state
    logic [7:0]  m_slot = 8'h00;
    logic [15:0] m_val [8];
    logic [6:0]  m_row [8];
    logic [6:0]  m_col [8];
    int          m_ptr = 7;
    logic        m_s1v = 1'b0;
    int          m_s1_bank, m_s1_entry;
    logic [15:0] m_s1_val;
    logic        m_err = 1'b0;
    logic        m_done = 1'b0;

    function automatic void addr_of(input logic [6:0] row, input logic [6:0] col,
                                    input logic [1:0] bwin, output int bank, output int entry);
        int bw, ru, rs;
        bw    = (bwin == 2'd3) ? 0 : int'(bwin);
        ru    = int'(row) / (1 << bw);
        rs    = int'(row) % (1 << bw);
        bank  = (int'(col) + 3 * ru + rs * (32 / (1 << bw))) % 32;
        entry = ru;
    endfunction

    // One clock cycle: predict this cycle's outputs from the inputs now applied, advance the model.
    task automatic step();
        status_t    s;
        acc_t       a;
        logic [7:0] orig;
        logic       found;
        int         w, bank, entry;
        orig   = m_slot;
        s.cts  = reset ? 8'h00 : ~m_slot;
        s.err  = m_err;
        s.done = m_done;
        s.re   = 1'b0;
        s.we   = 1'b0;
        if (!reset && m_s1v) begin
            golden[m_s1_bank][m_s1_entry] = golden[m_s1_bank][m_s1_entry] + m_s1_val;
            a.bank  = m_s1_bank;
            a.entry = m_s1_entry;
            a.data  = golden[m_s1_bank][m_s1_entry];
            wrq.push_back(a);
            s.we = 1'b1;
        end
        found = 1'b0;
        w = 0; bank = 0; entry = 0;
        if (!reset && buffer_grant) begin
            for (int k = 1; k <= 8; k++) begin
                int idx;
                idx = (m_ptr + k) % 8;
                if (!found && m_slot[idx]) begin
                    found = 1'b1;
                    w = idx;
                end
            end
        end
        if (found) begin
            addr_of(m_row[w], m_col[w], bitwidth, bank, entry);
            a.bank  = bank;
            a.entry = entry;
            a.data  = 16'h0;
            rdq.push_back(a);
            s.re = 1'b1;
        end
        stq.push_back(s);
        if (reset) begin
            m_slot = 8'h00; m_ptr = 7; m_s1v = 1'b0; m_err = 1'b0; m_done = 1'b0;
        end else begin
            if (merge_start) m_done = 1'b0;
            else if ((&neighbor_exchange_done) && orig == 8'h00) m_done = 1'b1;
            if (merge_start) m_err = 1'b0;
            else if (|(in_write_enable & orig)) m_err = 1'b1;
            m_s1v = found;
            if (found) begin
                m_s1_bank = bank; m_s1_entry = entry; m_s1_val = m_val[w];
                m_slot[w] = 1'b0;
                m_ptr = w;
            end
            for (int i = 0; i < 8; i++) begin
                if (in_write_enable[i] && !orig[i]) begin
                    m_slot[i] = 1'b1;
                    m_val[i]  = in_value[i];
                    m_row[i]  = in_row[i];
                    m_col[i]  = in_column[i];
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_write_enable = 8'h00;
        merge_start     = 1'b0;
    endtask

    task automatic send(input int n, input logic [15:0] v, input int row, input int col);
        in_write_enable[n] = 1'b1;
        in_value[n]        = v;
        in_row[n]          = 7'(row);
        in_column[n]       = 7'(col);
    endtask

    // Buffer model: one-cycle read latency, read sees pre-write data on a collision.
    initial begin
        logic        re, we;
        int          rb, rent, wb, went;
        logic [15:0] wd, rd;
        buffer_data_read = 16'h0;
        forever begin
            @(negedge clk);
            #3;
            re = buffer_read_enable; rb = int'(buffer_read_bank); rent = int'(buffer_read_entry);
            we = buffer_write_enable; wb = int'(buffer_write_bank); went = int'(buffer_write_entry);
            wd = buffer_write_data;
            @(posedge clk);
            #1;
            rd = mem[rb][rent];
            if (we === 1'b1) mem[wb][went] = wd;
            if (re === 1'b1) buffer_data_read = rd;
        end
    end

    // Monitor
    initial begin
        status_t s;
        acc_t    a;
        forever begin
            @(negedge clk);
            #2;
            if (stq.size() != 0) begin
                s = stq.pop_front();
                check("cts", neighbor_cts, s.cts);
                check("read_enable", buffer_read_enable, s.re);
                check("write_enable", buffer_write_enable, s.we);
                check("protocol_error", protocol_error, s.err);
                check("merge_done", merge_done, s.done);
                if (s.re) begin
                    a = rdq.pop_front();
                    if (buffer_read_enable === 1'b1) begin
                        check("read_bank", buffer_read_bank, a.bank);
                        check("read_entry", buffer_read_entry, a.entry);
                    end
                end
                if (s.we) begin
                    a = wrq.pop_front();
                    if (buffer_write_enable === 1'b1) begin
                        check("write_bank", buffer_write_bank, a.bank);
                        check("write_entry", buffer_write_entry, a.entry);
                        check("write_data", buffer_write_data, a.data);
                    end
                end
            end
        end
    end

    initial begin
        for (int b = 0; b < 32; b++)
            for (int e = 0; e < 128; e++)
                set_cell(b, e, 16'($urandom));
        reset = 1'b1; bitwidth = 2'd0; merge_start = 1'b0; in_write_enable = 8'h00;
        neighbor_exchange_done = 8'h00; buffer_grant = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_value[i] = 16'h0; in_row[i] = 7'h0; in_column[i] = 7'h0;
        end
        @(posedge clk);
        @(negedge clk);
        step();
        reset = 1'b0;

        // Single write, bitwidth 0: bank 22 entry 5, 100 + 20
        set_cell(22, 5, 16'd100);
        buffer_grant = 1'b1;
        send(3, 16'd20, 5, 7);
        repeat (4) step();
        check("cell_22_5", mem[22][5], 16'd120);

        // bitwidth 1 address map and wrap
        bitwidth = 2'd1;
        set_cell(29, 2, 16'h7FFF);
        send(0, 16'd1, 5, 7);
        repeat (4) step();
        check("cell_29_2_wrap", mem[29][2], 16'h8000);

        // Corner cell hit from three neighbours: forwarding chain
        bitwidth = 2'd0;
        set_cell(0, 0, 16'd10);
        send(0, 16'd1, 0, 0); send(1, 16'd2, 0, 0); send(3, 16'd4, 0, 0);
        repeat (6) step();
        check("corner_cell", mem[0][0], 16'd17);

        // All slots full from reset pointer, then grant withheld
        reset = 1'b1;
        step();
        reset = 1'b0;
        buffer_grant = 1'b0;
        for (int i = 0; i < 8; i++) send(i, 16'(i + 1), i, 0);
        step();
        buffer_grant = 1'b1;
        repeat (8) step();
        buffer_grant = 1'b0;
        repeat (3) step();

        // Protocol error: second write to an occupied slot is dropped
        send(5, 16'd7, 9, 9);
        step();
        send(5, 16'd99, 1, 1);
        step();
        check("error_sticky", protocol_error, 1'b1);
        buffer_grant = 1'b1;
        repeat (3) step();
        merge_start = 1'b1;
        repeat (2) step();

        // Done with one slot pending, merge_start priority, then reset mid-merge
        neighbor_exchange_done = 8'hFF;
        buffer_grant = 1'b0;
        send(2, 16'd5, 3, 3);
        repeat (2) step();
        buffer_grant = 1'b1;
        repeat (4) step();
        merge_start = 1'b1;
        repeat (3) step();
        buffer_grant = 1'b0;
        for (int i = 0; i < 4; i++) send(i, 16'(i + 40), i + 2, 5);
        step();
        buffer_grant = 1'b1;
        step();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        repeat (3) step();

        // Randomized traffic on a few hot cells, every bitwidth mode
        neighbor_exchange_done = 8'h00;
        for (int bw = 0; bw < 4; bw++) begin
            bitwidth = 2'(bw);
            repeat (150) begin
                buffer_grant = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < 8; i++)
                    if (!m_slot[i] && $urandom_range(0, 1) == 1)
                        send(i, 16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                step();
            end
            buffer_grant = 1'b1;
            repeat (12) step();
        end
        neighbor_exchange_done = 8'hFF;
        repeat (3) step();
        check("final_done", merge_done, 1'b1);

        @(negedge clk);
        #5;
        check("read_queue_drained", rdq.size(), 0);
        check("write_queue_drained", wrq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/halo_merge_arbiter.md
Name: halo_merge_arbiter

Overview:
- Receives halo partial-sum writes from the 8 neighbouring tiles' output-partials exchange logic and accumulates them into the local partial-sum buffer.
- Each neighbour has a one-entry holding slot with a clear-to-send handshake.
- Slots are arbitrated round-robin into a single read-modify-write pipeline on the buffer port.
- Signals completion when all neighbours report exchange done and all traffic has drained.

Parameters:
BANK_COUNT, 32, number of buffer banks (power of 2)
TILE_SIZE, 128, maximum tile edge; row/column width is $clog2(TILE_SIZE)
DATA_WIDTH, 16, partial-sum width, two's complement

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
bitwidth  in  2  activation bitwidth mode; static during a merge
merge_start  in  1  pulse; clears merge_done and protocol_error
in_value[8]  in  DATA_WIDTH  incoming halo value per neighbour (index order TOP_LEFT..BOTTOM_RIGHT)
in_row[8]  in  $clog2(TILE_SIZE)  local row of the incoming value
in_column[8]  in  $clog2(TILE_SIZE)  local column of the incoming value
in_write_enable[8]  in  1  incoming value valid
neighbor_cts[8]  out  1  clear to send, per neighbour
neighbor_exchange_done[8]  in  1  level; neighbour has finished sending
buffer_grant  in  1  local buffer port available for a new read this cycle
buffer_read_enable  out  1  read issue
buffer_read_bank  out  $clog2(BANK_COUNT)  read bank
buffer_read_entry  out  $clog2(TILE_SIZE)  read entry
buffer_data_read  in  DATA_WIDTH  read data, valid one cycle after issue
buffer_write_enable  out  1  write strobe
buffer_write_bank  out  $clog2(BANK_COUNT)  write bank
buffer_write_entry  out  $clog2(TILE_SIZE)  write entry
buffer_write_data  out  DATA_WIDTH  accumulated value
merge_done  out  1  all halo traffic merged
protocol_error  out  1  sticky; a write arrived while cts was low

Behaviour:
- **Reset** (synchronous): all slots empty, pipeline empty, RR pointer=7, merge_done=0, protocol_error=0. While reset is high, neighbor_cts=0 and read/write enables=0. From the first cycle after reset, cts=1 for all neighbours.
- **Slots / handshake:**
  - neighbor_cts[i] = !slot_valid[i] (combinational from register).
  - in_write_enable[i] with cts[i]=1 captures value/row/column into slot i at the clock edge.
  - in_write_enable[i] with cts[i]=0: data dropped, protocol_error set (sticky).
  - A slot granted in cycle t is empty at t+1, so cts rises at t+1; capture and grant never overlap in the same slot.
- **Arbitration (S0):**
  - Issue occurs only when buffer_grant=1 and at least one slot is valid.
  - Winner is the first valid slot scanning from (pointer+1) mod 8 upward. Pointer takes the winner index, updated only on a grant.
  - One grant per cycle.
  - Issue drives buffer_read_enable=1, bank, and entry combinationally in the same cycle. Winner address and value are registered into S1.
- **Address map:**
  - row_upper = row>>bitwidth; row_section = row mod 2^bitwidth; small = BANK_COUNT>>bitwidth.
  - bank = (column + 3*row_upper + row_section*small) mod BANK_COUNT.
  - entry = row_upper.
  - bitwidth=3 is treated as 0.
- **Accumulate (S1, cycle after issue):**
  - sum = operand + S1.value, wrapping modulo 2^DATA_WIDTH, no saturation.
  - buffer_write_enable=1 with S1 bank/entry/sum, driven combinationally in this cycle.
  - Latency: capture edge t → issue at earliest t+1 → write at t+2.
- **Hazard forwarding:**
  - The buffer returns old data when a read and a write hit the same address in the same cycle.
  - If the S0 issue address equals the S1 write address in the same cycle, a registered forward flag is set together with the S1 sum.
  - In the following cycle, operand = the forwarded sum instead of buffer_data_read. Otherwise operand = buffer_data_read.
  - Back-to-back hits to one cell (a corner cell receiving from 3 neighbours) accumulate correctly.
- **Done:**
  - merge_done is set one cycle after all 8 neighbor_exchange_done=1, all slots empty, and S1 empty.
  - It stays high until merge_start or reset.
  - merge_start has priority over a simultaneous set condition (done=0 that cycle, re-evaluated next cycle).
  - merge_start does not flush slots or the pipeline.
- **buffer_grant low:** no issue; S1 still completes its write.
- **Reset mid-operation:** in-flight S1 write is abandoned (no write strobe); slots are discarded.

Test Plan:
- bitwidth=0, buffer cell (bank 22, entry 5)=100; neighbour 3 sends value 20, row 5, col 7 at t → read bank 22 entry 5 at t+1; write 120 to bank 22 entry 5 at t+2; cts[3]=0 at t+1, 1 at t+2.
- bitwidth=1, row 5 col 7 → bank 29, entry 2; value 0x7FFF + 1 with cell=0x7FFF → write 0x8000 (wrap).
- Neighbours 0, 1, 3 all send to row 0 col 0 (cell=10) with values 1, 2, 4 in one cycle → grants 0, 1, 3 in consecutive cycles; final write 17 via forwarding, intermediate writes 11 and 13.
- All 8 slots full with buffer_grant=1 and pointer=7 → grant order 0..7. Then buffer_grant=0 for 3 cycles → no reads issued; pending S1 write still occurs.
- in_write_enable[5]=1 while cts[5]=0 → protocol_error=1 and slot content unchanged. merge_start → error=0.
- All exchange_done=1 with one slot pending → merge_done rises exactly 1 cycle after the final write cycle. Reset asserted mid-merge → outputs return to reset values next edge, cts=0 while reset is high.
